// File: rtl/brick_grid_scan.sv
// Brick-field scanner: walks a ROWS x COLS grid in row-major order and issues one
// rectangle-draw request per eligible brick over a valid/ready handshake.
module brick_grid_scan #(
   parameter int COLS    = 16,
   parameter int ROWS    = 4,
   parameter int BRICK_W = 10,
   parameter int BRICK_H = 5,
   parameter int X0      = 0,
   parameter int Y0      = 0,
   parameter int COORD_W = 10
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start,
   input  logic [ROWS*COLS-1:0] alive,
   input  logic                 skip_dead,
   input  logic                 draw_ready,
   output logic                 draw,
   output logic                 erase,
   output logic [COORD_W-1:0]   x_out,
   output logic [COORD_W-1:0]   y_out,
   output logic                 busy,
   output logic                 done
);

   localparam int N  = ROWS * COLS;
   localparam int IW = (N > 1)    ? $clog2(N)    : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [COORD_W-1:0] X0_C     = COORD_W'(X0);
   localparam logic [COORD_W-1:0] Y0_C     = COORD_W'(Y0);
   localparam logic [COORD_W-1:0] BW_C     = COORD_W'(BRICK_W);
   localparam logic [COORD_W-1:0] BH_C     = COORD_W'(BRICK_H);
   localparam logic [CW-1:0]      COL_LAST = CW'(COLS - 1);
   localparam logic [RW-1:0]      ROW_LAST = RW'(ROWS - 1);

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ISSUE, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [N-1:0]         alive_q, alive_d;
   logic                 skip_q, skip_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [CW-1:0]        col_q, col_d;
   logic [RW-1:0]        row_q, row_d;
   logic [COORD_W-1:0]   x_q, x_d;
   logic [COORD_W-1:0]   y_q, y_d;
   logic                 draw_q, draw_d;
   logic                 erase_q, erase_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 eligible, last_brick, advance;

   always_comb begin
      state_d  = state_q;
      alive_d  = alive_q;
      skip_d   = skip_q;
      idx_d    = idx_q;
      col_d    = col_q;
      row_d    = row_q;
      x_d      = x_q;
      y_d      = y_q;
      draw_d   = 1'b0;
      erase_d  = 1'b0;
      done_d   = 1'b0;
      advance  = 1'b0;

      eligible   = alive_q[idx_q] | ~skip_q;
      last_brick = (row_q == ROW_LAST) && (col_q == COL_LAST);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               alive_d = alive;
               skip_d  = skip_dead;
               idx_d   = '0;
               col_d   = '0;
               row_d   = '0;
               x_d     = X0_C;
               y_d     = Y0_C;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (eligible) begin
               state_d = S_ISSUE;
               draw_d  = 1'b1;
               erase_d = ~alive_q[idx_q];
            end else if (last_brick) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               advance = 1'b1;
            end
         end
         S_ISSUE: begin
            // Request and coordinates stay frozen until the drawer accepts.
            if (draw_q && draw_ready) begin
               if (last_brick) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_CHECK;
                  advance = 1'b1;
               end
            end else begin
               draw_d  = 1'b1;
               erase_d = erase_q;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (advance) begin
         idx_d = idx_q + IW'(1);
         if (col_q == COL_LAST) begin
            col_d = '0;
            x_d   = X0_C;
            row_d = row_q + RW'(1);
            y_d   = y_q + BH_C;
         end else begin
            col_d = col_q + CW'(1);
            x_d   = x_q + BW_C;
         end
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         alive_q <= '0;
         skip_q  <= 1'b0;
         idx_q   <= '0;
         col_q   <= '0;
         row_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         draw_q  <= 1'b0;
         erase_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         alive_q <= alive_d;
         skip_q  <= skip_d;
         idx_q   <= idx_d;
         col_q   <= col_d;
         row_q   <= row_d;
         x_q     <= x_d;
         y_q     <= y_d;
         draw_q  <= draw_d;
         erase_q <= erase_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign draw  = draw_q;
   assign erase = erase_q;
   assign x_out = x_q;
   assign y_out = y_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_brick_grid_scan.sv
// Randomised self-checking bench for brick_grid_scan against a row-major brick list model.
module tb_brick_grid_scan;

   localparam int COLS    = 16;
   localparam int ROWS    = 4;
   localparam int BRICK_W = 10;
   localparam int BRICK_H = 5;
   localparam int X0      = 0;
   localparam int Y0      = 0;
   localparam int COORD_W = 10;
   localparam int N       = ROWS * COLS;

   logic               clk = 1'b0;
   logic               resetn;
   logic               start;
   logic [N-1:0]       alive;
   logic               skip_dead;
   logic               draw_ready;
   logic               draw;
   logic               erase;
   logic [COORD_W-1:0] x_out;
   logic [COORD_W-1:0] y_out;
   logic               busy;
   logic               done;

   int checks = 0;
   int errors = 0;
   int xfer_x[$];
   int xfer_y[$];
   int full_x[$];
   int full_y[$];

   brick_grid_scan #(
      .COLS(COLS), .ROWS(ROWS), .BRICK_W(BRICK_W), .BRICK_H(BRICK_H),
      .X0(X0), .Y0(Y0), .COORD_W(COORD_W)
   ) dut (
      .clk(clk), .resetn(resetn), .start(start), .alive(alive),
      .skip_dead(skip_dead), .draw_ready(draw_ready), .draw(draw),
      .erase(erase), .x_out(x_out), .y_out(y_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_draw"},  draw,  0);
      check_val({tag, "_erase"}, erase, 0);
      check_val({tag, "_x"},     x_out, 0);
      check_val({tag, "_y"},     y_out, 0);
      check_val({tag, "_busy"},  busy,  0);
      check_val({tag, "_done"},  done,  0);
   endtask

   // rmode: 0 ready always high, 1 random ready, 2 stall the 3rd request 5 cycles.
   task automatic run_frame(input logic [N-1:0] a, input logic sk, input int rmode,
                            input logic disturb);
      int ex[$], ey[$], ee[$];
      int n, first_n, last_n, done_n, req, stall, total;
      logic pend, pe;
      logic [COORD_W-1:0] px, py;
      for (int i = 0; i < N; i++) begin
         if (a[i] || !sk) begin
            ex.push_back((X0 + (i % COLS) * BRICK_W) % (1 << COORD_W));
            ey.push_back((Y0 + (i / COLS) * BRICK_H) % (1 << COORD_W));
            ee.push_back(a[i] ? 0 : 1);
         end
      end
      total = ex.size();
      xfer_x.delete();
      xfer_y.delete();
      @(negedge clk);
      alive = a; skip_dead = sk; start = 1'b1; draw_ready = 1'b1;
      n = 0; first_n = -1; last_n = -1; done_n = -1; req = 0; stall = 0;
      pend = 1'b0; pe = 1'b0; px = '0; py = '0;
      while (n < 3000 && done_n < 0) begin
         @(negedge clk);
         n++;
         start = 1'b0;
         if (n == 1) begin
            check_val("busy_after_start", busy, 1);
            check_val("draw_at_first_cycle", draw, 0);
         end
         check_val("draw_done_overlap", draw & done, 0);
         if (pend) begin
            check_val("hold_draw",  draw,  1);
            check_val("hold_x",     x_out, px);
            check_val("hold_y",     y_out, py);
            check_val("hold_erase", erase, pe);
         end
         if (draw && first_n < 0) first_n = n;
         case (rmode)
            1:       draw_ready = 1'($urandom_range(0, 1));
            2: begin
               if (draw && req == 2 && stall < 5) begin
                  draw_ready = 1'b0;
                  stall++;
                  check_val("stall_x", x_out, 20);
                  check_val("stall_y", y_out, 0);
               end else begin
                  draw_ready = 1'b1;
               end
            end
            default: draw_ready = 1'b1;
         endcase
         if (draw && draw_ready) begin
            $display("XFER %0d x=%0d y=%0d erase=%0d", req, x_out, y_out, erase);
            if (ex.size() == 0) begin
               check_val("unexpected_xfer_x", x_out, 32'hFFFF_FFFF);
            end else begin
               check_val("xfer_x",     x_out, ex.pop_front());
               check_val("xfer_y",     y_out, ey.pop_front());
               check_val("xfer_erase", erase, ee.pop_front());
            end
            xfer_x.push_back(int'(x_out));
            xfer_y.push_back(int'(y_out));
            req++;
            last_n = n;
         end
         pend = draw && !draw_ready;
         px = x_out; py = y_out; pe = erase;
         if (done) done_n = n;
         if (disturb && busy && !done && (n % 7 == 3)) begin
            start = 1'b1;
            alive = ~alive;
            skip_dead = ~skip_dead;
         end
      end
      start = 1'b0;
      check_val("done_seen", done_n >= 0, 1);
      check_val("xfer_count", req, total);
      if (total > 0 && (a[0] || !sk)) check_val("first_draw_latency", first_n, 2);
      if (total == 0) check_val("no_draw_first", first_n, -1);
      if (a[N-1] || !sk) check_val("done_after_last", done_n, last_n + 1);
      if (sk && a == '0) check_val("empty_done_cycle", done_n, N + 1);
      if (rmode == 2) check_val("stall_cycles", stall, 5);
      @(negedge clk);
      check_val("done_one_cycle", done, 0);
      check_val("idle_busy", busy, 0);
      check_val("idle_draw", draw, 0);
      $display("FRAME skip=%0d mode=%0d xfers=%0d done_cycle=%0d", sk, rmode, req, done_n);
   endtask

   initial begin
      logic [N-1:0] ra;
      resetn = 1'b0; start = 1'b0; alive = '0; skip_dead = 1'b0; draw_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      resetn = 1'b1;

      run_frame({N{1'b1}}, 1'b0, 0, 1'b0);
      check_val("full_count", xfer_x.size(), 64);
      if (xfer_x.size() == 64) begin
         check_val("full_first_x", xfer_x[0], 0);
         check_val("full_first_y", xfer_y[0], 0);
         check_val("full_16_x", xfer_x[15], 150);
         check_val("full_16_y", xfer_y[15], 0);
         check_val("full_17_x", xfer_x[16], 0);
         check_val("full_17_y", xfer_y[16], 5);
         check_val("full_last_x", xfer_x[63], 150);
         check_val("full_last_y", xfer_y[63], 15);
      end
      full_x = xfer_x;
      full_y = xfer_y;

      run_frame('0, 1'b0, 0, 1'b0);
      check_val("erase_count", xfer_x.size(), full_x.size());
      if (xfer_x.size() == full_x.size()) begin
         for (int i = 0; i < full_x.size(); i++) begin
            check_val("erase_seq_x", xfer_x[i], full_x[i]);
            check_val("erase_seq_y", xfer_y[i], full_y[i]);
         end
      end

      run_frame({1'b1, {(N-2){1'b0}}, 1'b1}, 1'b1, 0, 1'b0);
      check_val("skip_count", xfer_x.size(), 2);
      if (xfer_x.size() == 2) begin
         check_val("skip_first_x", xfer_x[0], 0);
         check_val("skip_first_y", xfer_y[0], 0);
         check_val("skip_last_x", xfer_x[1], 150);
         check_val("skip_last_y", xfer_y[1], 15);
      end

      run_frame('0, 1'b1, 0, 1'b0);
      run_frame({N{1'b1}}, 1'b0, 2, 1'b0);

      ra = {$urandom(), $urandom()};
      run_frame(ra, 1'b1, 0, 1'b1);
      ra = {$urandom(), $urandom()};
      run_frame(ra, 1'b0, 1, 1'b1);

      // Reset in the middle of a frame.
      @(negedge clk);
      alive = {N{1'b1}}; skip_dead = 1'b0; start = 1'b1; draw_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      resetn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_all_zero("midscan_reset");
      end
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("post_reset_done", done, 0);
         check_val("post_reset_busy", busy, 0);
      end
      run_frame({N{1'b1}}, 1'b0, 0, 1'b0);
      if (xfer_x.size() > 0) begin
         check_val("restart_x", xfer_x[0], X0);
         check_val("restart_y", xfer_y[0], Y0);
      end

      for (int f = 0; f < 6; f++) begin
         ra = {$urandom(), $urandom()};
         run_frame(ra, 1'($urandom_range(0, 1)), 1, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
